fifo_stream_adapter: RTL and testbench
======================================

FIFO_STREAM_ADAPTER -- requirements
Module: fifo_stream_adapter

Interface
REQ-001 SHALL have parameter G_FWFT, default 0, meaning upstream FIFO mode (0 = standard with 1-cycle read latency, 1 = first-word-fall-through).
REQ-002 SHALL have parameter G_DATAWIDTH, default 32, meaning data width in bits.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; every flop is clocked by its rising edge.
REQ-004 SHALL have port nrst, input, 1 bit, reset, asynchronous and active-low.
REQ-005 SHALL have port flush, input, 1 bit, synchronous active-high flush of the buffered data.
REQ-006 SHALL have port fifo_dout, input, G_DATAWIDTH bits, read data from the upstream sfifo.
REQ-007 SHALL have port fifo_empty, input, 1 bit, upstream empty flag.
REQ-008 SHALL have port fifo_rd_en, output, 1 bit, pop request to the upstream FIFO.
REQ-009 SHALL have port m_tdata, output, G_DATAWIDTH bits, stream data.
REQ-010 SHALL have port m_tvalid, output, 1 bit, stream valid.
REQ-011 SHALL have port m_tready, input, 1 bit, stream ready from the consumer.
REQ-012 SHALL have port level, output, 2 bits, count of entries held in the local buffer (0..3).

Function
REQ-013 SHALL hold a 3-entry circular buffer with read and write pointers that wrap 2 -> 0.
REQ-014 SHALL compute fifo_rd_en = !fifo_empty && !flush && (level + inflight) < 3, using registered state only and no combinational path from m_tready.
REQ-015 With G_FWFT=0, SHALL set inflight to the registered fifo_rd_en and SHALL write fifo_dout into the buffer one cycle after fifo_rd_en.
REQ-016 With G_FWFT=1, SHALL hold inflight at 0 and SHALL write fifo_dout into the buffer in the same cycle that fifo_rd_en is high.
REQ-017 SHALL drive m_tvalid = (level != 0) and m_tdata = the entry at the read pointer.
REQ-018 SHALL treat a handshake (m_tvalid && m_tready) as a pop: advance the read pointer and decrement level at the next edge.
REQ-019 On simultaneous write and pop, SHALL leave level unchanged and advance both pointers.
REQ-020 SHALL hold m_tdata stable while m_tvalid=1 and m_tready=0.
REQ-021 SHALL sustain one transfer per cycle when fifo_empty=0 and m_tready=1 continuously, in both modes.
REQ-022 Flush SHALL zero both pointers and level at the next edge, and SHALL discard read data still arriving from a read issued during or one cycle before the flush.
REQ-023 SHALL never write a full buffer; the credit rule in REQ-014 guarantees this, and an assertion SHALL check it.

Reset
REQ-024 While nrst=0, SHALL asynchronously clear the pointers, level, inflight and the discard flag, giving m_tvalid=0, fifo_rd_en=0 and level=0.
REQ-025 SHALL leave buffer storage unreset; m_tdata is don't-care while m_tvalid=0.
REQ-026 If reset occurs with a read in flight, SHALL drop the returned word; the upstream FIFO is not rewound.

Structure
REQ-027 SHALL place the buffer depth constant (3) and the level type in the shared fifo_pkg package.
REQ-028 SHALL implement the storage and pointers as one sub-module, skid_ring, with the credit and flush logic in the top level.

Verification
REQ-029 Streaming, G_FWFT=0: upstream preloaded with 0x01..0x10, m_tready=1 -> first m_tvalid 2 cycles after fifo_empty falls, then 16 consecutive beats 0x01..0x10 with no gaps.
REQ-030 Backpressure: m_tready=0 with 8 words upstream -> level reaches 3, fifo_rd_en=0 thereafter, m_tdata holds 0x01; release ready -> 0x01..0x08 in order with none lost.
REQ-031 FWFT mode: G_FWFT=1 with the same 16 words -> first beat in the cycle after fifo_empty falls, all 16 in order.
REQ-032 Flush with a read in flight: assert flush with level=2 and fifo_rd_en high the prior cycle -> level=0 next cycle, the late word is not presented, and the next beat is the following upstream word.
REQ-033 Reset mid-stream: pull nrst low during beat 5 -> m_tvalid and fifo_rd_en fall immediately without a clock edge, and level=0.
REQ-034 Random m_tready at 50% over 1000 words against the scoreboard -> data matches in order, and the overflow assertion never fires.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO-to-stream adapter.
package fifo_pkg;

  localparam int unsigned DEPTH = 3;

  typedef logic [1:0] level_t;
  typedef logic [1:0] ptr_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : ptr_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/skid_ring.sv
// Three-entry circular buffer: storage, read/write pointers and occupancy.
module skid_ring
  import fifo_pkg::*;
#(
  parameter int G_DATAWIDTH = 32
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [G_DATAWIDTH-1:0] wr_data,
  input  logic                   pop,
  output logic [G_DATAWIDTH-1:0] rd_data,
  output level_t                 level
);

  logic [G_DATAWIDTH-1:0] mem [DEPTH];
  ptr_t   wr_ptr;
  ptr_t   rd_ptr;
  level_t level_q;
  logic   wr_ok;
  logic   pop_ok;

  assign wr_ok  = wr_en && !flush;
  assign pop_ok = pop && (level_q != '0) && !flush;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_ok)  wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_ok, pop_ok})
        2'b10:   level_q <= level_t'(level_q + 2'd1);
        2'b01:   level_q <= level_t'(level_q - 2'd1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage is deliberately unreset; rd_data is only meaningful while level != 0.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign level   = level_q;

  a_no_overflow : assert property (@(posedge clk) disable iff (!nrst)
    !(wr_ok && (level_q == level_t'(DEPTH))));

endmodule

// File: rtl/fifo_stream_adapter.sv
// Turns a standard or FWFT synchronous FIFO read port into a ready/valid stream,
// using a credit count so the local ring never overflows and m_tready has no comb path upstream.
module fifo_stream_adapter
  import fifo_pkg::*;
#(
  parameter int G_FWFT      = 0,
  parameter int G_DATAWIDTH = 32
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   flush,
  input  logic [G_DATAWIDTH-1:0] fifo_dout,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  output logic [G_DATAWIDTH-1:0] m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [1:0]             level
);

  level_t     level_i;
  logic       inflight;
  logic       wr_en;
  logic       pop;
  logic [2:0] credit_used;

  assign credit_used = {1'b0, level_i} + {2'b00, inflight};
  // nrst gates the request so it drops the instant reset asserts, without waiting for an edge.
  assign fifo_rd_en  = nrst && !fifo_empty && !flush && (credit_used < 3'(DEPTH));

  if (G_FWFT != 0) begin : g_fwft
    assign inflight = 1'b0;
    assign wr_en    = fifo_rd_en;
  end else begin : g_std
    logic inflight_q;
    logic discard_q;

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        inflight_q <= 1'b0;
        discard_q  <= 1'b0;
      end else begin
        inflight_q <= fifo_rd_en;
        discard_q  <= flush;
      end
    end

    // A word returning during the flush cycle is dropped by the ring's flush priority;
    // discard_q guards the cycle right after.
    assign inflight = inflight_q;
    assign wr_en    = inflight_q && !discard_q;
  end

  assign m_tvalid = (level_i != '0);
  assign pop      = m_tvalid && m_tready;
  assign level    = level_i;

  skid_ring #(
    .G_DATAWIDTH(G_DATAWIDTH)
  ) u_ring (
    .clk    (clk),
    .nrst   (nrst),
    .flush  (flush),
    .wr_en  (wr_en),
    .wr_data(fifo_dout),
    .pop    (pop),
    .rd_data(m_tdata),
    .level  (level_i)
  );

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Runs a standard-mode and an FWFT-mode adapter side by side against queue-based upstream FIFOs and a scoreboard.
module tb_fifo_stream_adapter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          nrst;
  logic          flush;
  logic          m_tready;
  logic [DW-1:0] fifo_dout [2];
  logic          fifo_empty [2];
  logic          fifo_rd_en [2];
  logic [DW-1:0] m_tdata [2];
  logic          m_tvalid [2];
  logic [1:0]    level [2];

  logic [DW-1:0] up_q [2][$];
  logic [DW-1:0] exp_q [2][$];

  int            n_cmp = 0;
  int            n_err = 0;
  int            beats [2];
  int            pushed [2];
  int            first [2];
  int            gaps [2];
  logic [DW-1:0] first_beat [2];

  logic          rd_c [2];
  logic          hs_c [2];
  logic [DW-1:0] tdata_c [2];
  logic          flush_c;
  logic          nrst_c;

  always #5 clk = ~clk;

  fifo_stream_adapter #(.G_FWFT(0), .G_DATAWIDTH(DW)) dut_std (
    .clk(clk), .nrst(nrst), .flush(flush),
    .fifo_dout(fifo_dout[0]), .fifo_empty(fifo_empty[0]), .fifo_rd_en(fifo_rd_en[0]),
    .m_tdata(m_tdata[0]), .m_tvalid(m_tvalid[0]), .m_tready(m_tready), .level(level[0])
  );

  fifo_stream_adapter #(.G_FWFT(1), .G_DATAWIDTH(DW)) dut_fwft (
    .clk(clk), .nrst(nrst), .flush(flush),
    .fifo_dout(fifo_dout[1]), .fifo_empty(fifo_empty[1]), .fifo_rd_en(fifo_rd_en[1]),
    .m_tdata(m_tdata[1]), .m_tvalid(m_tvalid[1]), .m_tready(m_tready), .level(level[1])
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int m, input logic [DW-1:0] w);
    up_q[m].push_back(w);
    exp_q[m].push_back(w);
    if (m == 1) fifo_dout[1] = up_q[1][0];
    fifo_empty[m] = 1'b0;
  endtask

  task automatic capture();
    for (int m = 0; m < 2; m++) begin
      rd_c[m]    = fifo_rd_en[m];
      hs_c[m]    = m_tvalid[m] && m_tready;
      tdata_c[m] = m_tdata[m];
    end
    flush_c = flush;
    nrst_c  = nrst;
  endtask

  // Applies what the last rising edge did: consumer beats against the scoreboard, upstream pops.
  task automatic update();
    logic [DW-1:0] w;
    for (int m = 0; m < 2; m++) begin
      if (nrst_c && !flush_c && hs_c[m]) begin
        n_cmp++;
        assert (exp_q[m].size() != 0) else begin
          n_err++;
          $error("FAIL sb_extra_beat%0d observed=%0h expected=none", m, tdata_c[m]);
        end
        if (exp_q[m].size() != 0) begin
          w = exp_q[m].pop_front();
          check(m == 0 ? "sb_data_std" : "sb_data_fwft", tdata_c[m], w);
        end
        beats[m]++;
        if (beats[m] == 1) first_beat[m] = tdata_c[m];
      end
      if (rd_c[m]) begin
        n_cmp++;
        assert (up_q[m].size() != 0) else begin
          n_err++;
          $error("FAIL rd_when_empty%0d observed=1 expected=0", m);
        end
        if (up_q[m].size() != 0) begin
          w = up_q[m].pop_front();
          if (m == 0) fifo_dout[0] = w;
        end
      end
      if (m == 1) fifo_dout[1] = (up_q[1].size() != 0) ? up_q[1][0] : '0;
      fifo_empty[m] = (up_q[m].size() == 0);
      // Flush or reset discards everything already read; the stream restarts at the upstream head.
      if (!nrst_c || flush_c) exp_q[m] = up_q[m];
    end
  endtask

  task automatic tick();
    #1 capture();
    @(posedge clk);
    #1 update();
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    nrst = 1'b0;
    flush = 1'b0;
    m_tready = 1'b0;
    for (int m = 0; m < 2; m++) begin
      fifo_dout[m] = '0;
      fifo_empty[m] = 1'b1;
      beats[m] = 0;
      pushed[m] = 0;
    end

    // reset state
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      check("rst_tvalid", m_tvalid[m], 0);
      check("rst_rd_en", fifo_rd_en[m], 0);
      check("rst_level", level[m], 0);
    end
    tick();
    nrst = 1'b1;
    tick();
    tick();

    // streaming 0x01..0x10, ready held high
    m_tready = 1'b1;
    for (int m = 0; m < 2; m++) begin
      beats[m] = 0; first[m] = -1; gaps[m] = 0;
      for (int w = 1; w <= 16; w++) push(m, w);
    end
    for (int s = 0; s < 60 && (beats[0] < 16 || beats[1] < 16); s++) begin
      for (int m = 0; m < 2; m++) begin
        if (m_tvalid[m] && first[m] < 0) first[m] = s;
        if (first[m] >= 0 && !m_tvalid[m] && beats[m] < 16) gaps[m]++;
      end
      tick();
    end
    check("stream_first_valid_std", first[0], 2);
    check("stream_first_valid_fwft", first[1], 1);
    for (int m = 0; m < 2; m++) begin
      check("stream_gaps", gaps[m], 0);
      check("stream_beats", beats[m], 16);
    end

    // backpressure with 8 words upstream
    m_tready = 1'b0;
    for (int m = 0; m < 2; m++) begin
      beats[m] = 0;
      for (int w = 1; w <= 8; w++) push(m, w);
    end
    repeat (12) tick();
    for (int m = 0; m < 2; m++) begin
      check("bp_level", level[m], 3);
      check("bp_rd_en", fifo_rd_en[m], 0);
      check("bp_tdata", m_tdata[m], 32'h01);
      check("bp_tvalid", m_tvalid[m], 1);
    end
    m_tready = 1'b1;
    for (int s = 0; s < 40 && (beats[0] < 8 || beats[1] < 8); s++) tick();
    for (int m = 0; m < 2; m++) begin
      check("bp_beats", beats[m], 8);
      check("bp_left", exp_q[m].size(), 0);
    end

    // flush while a read is in flight in the standard-mode adapter
    m_tready = 1'b0;
    found = 0;
    for (int m = 0; m < 2; m++) begin
      beats[m] = 0;
      for (int w = 8'h21; w <= 8'h28; w++) push(m, w);
    end
    for (int s = 0; s < 12; s++) begin
      if (level[0] == 2'd2) begin
        found = 1;
        break;
      end
      tick();
    end
    check("flush_reach_lvl2", found, 1);
    check("flush_prior_rd", rd_c[0], 1);
    check("flush_rd_now", fifo_rd_en[0], 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int m = 0; m < 2; m++) begin
      check("flush_level", level[m], 0);
      check("flush_tvalid", m_tvalid[m], 0);
    end
    m_tready = 1'b1;
    for (int s = 0; s < 30 && (beats[0] < 5 || beats[1] < 5); s++) tick();
    for (int m = 0; m < 2; m++) begin
      check("flush_next_word", first_beat[m], 32'h24);
      check("flush_beats", beats[m], 5);
      check("flush_left", exp_q[m].size(), 0);
    end

    // reset during the fifth beat
    found = 0;
    for (int m = 0; m < 2; m++) begin
      beats[m] = 0;
      for (int w = 8'h31; w <= 8'h40; w++) push(m, w);
    end
    for (int s = 0; s < 40; s++) begin
      if (beats[0] == 4 && m_tvalid[0]) begin
        found = 1;
        break;
      end
      tick();
    end
    check("rstmid_reach_beat5", found, 1);
    nrst = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      check("rstmid_tvalid", m_tvalid[m], 0);
      check("rstmid_rd_en", fifo_rd_en[m], 0);
      check("rstmid_level", level[m], 0);
    end
    tick();
    tick();
    nrst = 1'b1;
    for (int s = 0; s < 60 && (exp_q[0].size() != 0 || exp_q[1].size() != 0); s++) tick();
    tick();
    for (int m = 0; m < 2; m++) begin
      check("rstmid_left", exp_q[m].size(), 0);
      check("rstmid_up_left", up_q[m].size(), 0);
      check("rstmid_idle_tvalid", m_tvalid[m], 0);
    end

    // random ready at 50% over 1000 words
    for (int m = 0; m < 2; m++) begin
      beats[m] = 0;
      pushed[m] = 0;
    end
    for (int s = 0; s < 20000 && (beats[0] < 1000 || beats[1] < 1000); s++) begin
      for (int m = 0; m < 2; m++) begin
        if (pushed[m] < 1000 && up_q[m].size() < 5 && $urandom_range(3) != 0) begin
          push(m, $urandom);
          pushed[m]++;
        end
      end
      m_tready = $urandom_range(1) != 0;
      tick();
    end
    for (int m = 0; m < 2; m++) begin
      check("rand_beats", beats[m], 1000);
      check("rand_left", exp_q[m].size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
